decode_group_buffer: RTL and testbench
======================================

# decode_group_buffer

Instruction buffer and multi-slot decode stage between fetch and rename. Accepts fetch bundles of up to FETCH_W instructions, holds them in a DEPTH-entry circular queue, and presents up to DEC_W decoded instructions (instr_info_t plus PC) per cycle to rename. It applies in-order group-formation rules (one control-flow per group, syscall isolated) and supports pipeline flush.

## Interface
- FETCH_W, 2: max instructions pushed per cycle (1..4)
- DEC_W, 2: max instructions presented/popped per cycle (1..4)
- DEPTH, 8: queue entries; power of 2, DEPTH >= 2*FETCH_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all queued entries
- in_valid  in  1  fetch bundle valid
- in_ready  out  1  queue can accept a full bundle
- in_count  in  $clog2(FETCH_W+1)  number of valid slots in bundle, slots 0..in_count-1
- in_instr  in  FETCH_W*32  raw instructions, slot i at [32i+31:32i]
- in_pc  in  32  PC of slot 0; slot i PC = in_pc + 4i (mod 2^32)
- out_valid  out  DEC_W  per-slot valid, always a contiguous prefix from bit 0
- out_info  out  DEC_W x instr_info_t  decoded fields per slot (one instruction_decoder per slot)
- out_pc  out  DEC_W*32  PC per slot
- out_ready  in  1  rename accepts every slot flagged in out_valid this cycle
- occupancy  out  $clog2(DEPTH+1)  current entry count

## Operation
- Storage: DEPTH entries of {instr[31:0], pc[31:0]}; head/tail pointers wrap modulo DEPTH; occupancy register.
- Push: in_ready = (DEPTH - occupancy) >= FETCH_W, computed on current occupancy only (no dependency on out_ready). On in_valid && in_ready, write in_count entries at tail, tail += in_count. in_count = 0 is a no-op.
- Group formation over candidate slots k = 0..min(DEC_W, occupancy)-1, read from head+k:
  - Slot k valid only if slot k-1 is valid and slot k-1 is not control-flow (cf_kind != CF_NONE) and not syscall.
  - Syscall at k > 0 is not valid (it ends the group before itself); syscall at slot 0 is presented alone.
  - OPC_INVALID instructions pass through unchanged (rename handles them).
- Pop: on out_ready with out_valid != 0, head += popcount(out_valid), all-or-nothing. Partial acceptance does not exist.
- Simultaneous push and pop: both apply; occupancy += in_count - popped.
- Flush: next cycle head = tail = 0, occupancy = 0. Flush overrides push and pop in the same cycle; out_valid is still driven from current state but nothing is popped.
- Reset (rst_n low, asynchronous): head = tail = occupancy = 0; out_valid = 0, occupancy = 0, in_ready = 1; out_info/out_pc hold decodes of entry contents (don't-care while invalid).

## Timing
- Default latency: an entry pushed at edge t appears on out_valid in the cycle after edge t (1 cycle).
- out_valid/out_info/out_pc are combinational from queue state (regs -> decoders -> group logic); no path from out_ready to out_valid.
- Full boundary: occupancy > DEPTH - FETCH_W forces in_ready = 0, even if a pop occurs in that cycle.
- Empty boundary: occupancy = 0 drives out_valid = 0 (unless bypass, below).
- Pointer wrap: group reads at head+k wrap modulo DEPTH; bundle writes straddling entry DEPTH-1 -> 0 are contiguous modulo DEPTH.

## Configuration
- DECODE_BUF_BYPASS_EN defined: when occupancy = 0, in_valid = 1 and flush = 0, output slots are sourced directly from in_instr/in_pc (limited to in_count) in the same cycle; group rules apply unchanged. Slots popped that cycle are not written to the queue; only the remainder is written, and tail advances by the remainder. This gives zero-cycle latency and adds a combinational in_* -> out_* path.
- Undefined: no bypass path; minimum latency is 1 cycle as stated under Timing.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with 5 entries queued -> out_valid = 0, occupancy = 0, in_ready = 1 immediately, without waiting for a clock edge.
- Push addu, subu at pc 0x1000 with count 2; out_ready = 1 -> next cycle out_valid = 2'b11, out_pc = {0x1004, 0x1000}; following cycle occupancy = 0.
- Queue beq, addu -> out_valid = 2'b01 (beq alone). Queue addu, syscall -> 2'b01, then syscall alone as 2'b01.
- Fill to occupancy 7 with DEPTH = 8, FETCH_W = 2 -> in_ready = 0; pop 2 -> in_ready = 1 next cycle; the following push wraps the tail from entry 7 to entry 0 with correct instruction order.
- Flush together with in_valid and out_ready at occupancy 4 -> next cycle occupancy = 0, out_valid = 0, nothing pushed.
- With DECODE_BUF_BYPASS_EN, empty queue, push 2 ALU ops with out_ready = 1 -> out_valid = 2'b11 in the same cycle, occupancy remains 0; without the macro -> out_valid = 2'b11 one cycle later.

Source files
------------

// File: rtl/decode_group_buffer_if.sv
// Shared decode types and the fetch/rename-facing bus of decode_group_buffer.
//
// decode_group_buffer_pkg
//   instr_info_t          : decoded fields of one instruction
//   instruction_decoder() : pure combinational decode of a raw 32-bit word
//
// decode_group_buffer_if #(FETCH_W, DEC_W, DEPTH)
//   flush, in_valid, in_count, in_instr, in_pc, out_ready : driven by master
//   in_ready, out_valid, out_info, out_pc, occupancy       : driven by slave
//
// Handshake rules for this bus:
//   - Push side: a bundle transfers on a rising edge where in_valid && in_ready
//     && !flush. in_ready depends only on the current occupancy, never on
//     out_ready or in_valid. Only slots 0..in_count-1 are meaningful.
//   - Pop side: every slot flagged in out_valid (a contiguous prefix from bit 0)
//     transfers on a rising edge where out_ready && !flush. Acceptance is
//     all-or-nothing; out_valid never depends on out_ready.

package decode_group_buffer_pkg;

  typedef enum logic [2:0] {
    OPC_ALU,
    OPC_LOAD,
    OPC_STORE,
    OPC_BRANCH,
    OPC_JUMP,
    OPC_SYSCALL,
    OPC_INVALID
  } opc_t;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JUMP,
    CF_JR
  } cf_kind_t;

  typedef struct packed {
    opc_t        opc;
    cf_kind_t    cf_kind;
    logic        is_syscall;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } instr_info_t;

  // MIPS-style decode; anything unrecognised is OPC_INVALID and flows on.
  function automatic instr_info_t instruction_decoder(input logic [31:0] instr);
    instr_info_t info;
    info.opc        = OPC_INVALID;
    info.cf_kind    = CF_NONE;
    info.is_syscall = 1'b0;
    info.rs         = instr[25:21];
    info.rt         = instr[20:16];
    info.rd         = instr[15:11];
    info.imm        = instr[15:0];
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h00, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: info.opc = OPC_ALU;
          6'h08: begin
            info.opc     = OPC_JUMP;
            info.cf_kind = CF_JR;
          end
          6'h0c: begin
            info.opc        = OPC_SYSCALL;
            info.is_syscall = 1'b1;
          end
          default: ;
        endcase
      end
      6'h02, 6'h03: begin
        info.opc     = OPC_JUMP;
        info.cf_kind = CF_JUMP;
      end
      6'h04, 6'h05: begin
        info.opc     = OPC_BRANCH;
        info.cf_kind = CF_BRANCH;
      end
      6'h09, 6'h0c, 6'h0d, 6'h0f: info.opc = OPC_ALU;
      6'h23: info.opc = OPC_LOAD;
      6'h2b: info.opc = OPC_STORE;
      default: ;
    endcase
    return info;
  endfunction

endpackage

interface decode_group_buffer_if #(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int DEPTH   = 8
);
  import decode_group_buffer_pkg::*;

  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic [$clog2(FETCH_W+1)-1:0]     in_count;
  logic [FETCH_W*32-1:0]            in_instr;
  logic [31:0]                      in_pc;
  logic [DEC_W-1:0]                 out_valid;
  instr_info_t [DEC_W-1:0]          out_info;
  logic [DEC_W*32-1:0]              out_pc;
  logic                             out_ready;
  logic [$clog2(DEPTH+1)-1:0]       occupancy;

  modport master (
    output flush, in_valid, in_count, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_info, out_pc, occupancy
  );

  modport slave (
    input  flush, in_valid, in_count, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_info, out_pc, occupancy
  );

endinterface

// File: rtl/decode_group_buffer.sv
// decode_group_buffer: instruction queue plus multi-slot decode between fetch
// and rename. Fetch bundles (up to FETCH_W) are written into a DEPTH-entry
// circular queue; up to DEC_W entries from the head are decoded each cycle and
// trimmed into an issue group (one control-flow per group, syscall alone).
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : decode_group_buffer_if.slave (fetch push, rename pop, flush,
//           occupancy)
//
// Optional feature: define DECODE_BUF_BYPASS_EN to let an empty queue present
// the incoming bundle in the same cycle (zero-latency bypass).

module decode_group_buffer
  import decode_group_buffer_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int DEPTH   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  decode_group_buffer_if.slave bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int OW   = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(DEC_W + 1);
  localparam int XW   = (FETCH_W > DEC_W) ? FETCH_W : DEC_W;
  localparam int PADW = 32 * XW;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [OW-1:0] occ;

  logic              byp;
  logic [PADW-1:0]   in_pad;
  logic [31:0]       cand_instr [DEC_W];
  logic [31:0]       cand_pc    [DEC_W];
  logic [DEC_W-1:0]  cand_avail;
  instr_info_t       cand_info  [DEC_W];
  logic [DEC_W-1:0]  grp_valid;
  logic [SW-1:0]     grp_cnt;
  logic [SW-1:0]     pop_n;
  logic              push_ok;
  int                skip;

`ifdef DECODE_BUF_BYPASS_EN
  assign byp = (occ == '0) && bus.in_valid && !bus.flush;
`else
  assign byp = 1'b0;
`endif

  // Widened copy so slot k can be sliced even when DEC_W > FETCH_W.
  assign in_pad = PADW'(bus.in_instr);

  // Candidate k comes from head+k (wraps naturally, DEPTH is a power of 2),
  // or straight from the fetch bundle while bypassing an empty queue.
  always_comb begin
    for (int k = 0; k < DEC_W; k++) begin
      cand_instr[k] = mem_instr[head + PW'(k)];
      cand_pc[k]    = mem_pc[head + PW'(k)];
      cand_avail[k] = k < int'(occ);
      if (byp) begin
        cand_instr[k] = in_pad[32*k +: 32];
        cand_pc[k]    = bus.in_pc + 32'(4 * k);
        cand_avail[k] = k < int'(bus.in_count);
      end
    end
  end

  for (genvar g = 0; g < DEC_W; g++) begin : g_dec
    assign cand_info[g] = instruction_decoder(cand_instr[g]);
  end

  // A slot joins the group only if everything before it joined and the
  // previous slot did not end the group; a syscall never joins behind others.
  always_comb begin
    grp_valid    = '0;
    grp_valid[0] = cand_avail[0];
    for (int k = 1; k < DEC_W; k++) begin
      grp_valid[k] = cand_avail[k] && grp_valid[k-1]
                  && (cand_info[k-1].cf_kind == CF_NONE)
                  && !cand_info[k-1].is_syscall
                  && !cand_info[k].is_syscall;
    end
  end

  always_comb begin
    grp_cnt = '0;
    for (int k = 0; k < DEC_W; k++) begin
      grp_cnt = grp_cnt + SW'(grp_valid[k]);
    end
  end

  assign pop_n   = (bus.out_ready && !bus.flush) ? grp_cnt : '0;
  assign push_ok = bus.in_valid && bus.in_ready && !bus.flush;
  // In bypass the popped slots never touch the queue; skip them on write.
  assign skip    = byp ? int'(pop_n) : 0;

  assign bus.in_ready  = occ <= OW'(DEPTH - FETCH_W);
  assign bus.occupancy = occ;
  assign bus.out_valid = grp_valid;

  always_comb begin
    for (int k = 0; k < DEC_W; k++) begin
      bus.out_info[k]         = cand_info[k];
      bus.out_pc[32*k +: 32]  = cand_pc[k];
    end
  end

  // Storage carries no reset; contents are don't-care while not occupied.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i >= skip && i < int'(bus.in_count)) begin
          mem_instr[tail + PW'(i - skip)] <= bus.in_instr[32*i +: 32];
          mem_pc[tail + PW'(i - skip)]    <= bus.in_pc + 32'(4 * i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (!byp) head <= head + PW'(pop_n);
      if (push_ok) tail <= tail + PW'(int'(bus.in_count) - skip);
      occ <= occ + (push_ok ? OW'(bus.in_count) : '0) - OW'(pop_n);
    end
  end

endmodule

// File: tb/tb_decode_group_buffer.sv
// Self-checking bench for decode_group_buffer. A queue-based reference model
// tracks queued instructions by pool index and PC; expected groups come from
// the pool's known control-flow/syscall properties. Honours
// DECODE_BUF_BYPASS_EN when it is defined for the build.

module tb_decode_group_buffer;
  import decode_group_buffer_pkg::*;

  localparam int FETCH_W = 2;
  localparam int DEC_W   = 2;
  localparam int DEPTH   = 8;
  localparam int CW      = $clog2(FETCH_W + 1);

`ifdef DECODE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_group_buffer_if #(.FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH)) bus ();

  decode_group_buffer #(.FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- instruction pool ----------------
  // 0 addu, 1 subu, 2 beq, 3 j, 4 jr, 5 syscall, 6 lw, 7 undefined opcode
  logic [31:0] pool_instr [8];
  opc_t        pool_opc   [8];

  function automatic bit is_cf(input int idx);
    return (idx == 2) || (idx == 3) || (idx == 4);
  endfunction

  function automatic bit is_sys(input int idx);
    return idx == 5;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Each entry: {pool index[7:0], pc[31:0]}
  logic [39:0] exp_q[$];
  int          drv_idx [FETCH_W];

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int cnt, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_count  = CW'(cnt);
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    for (int i = 0; i < FETCH_W; i++) bus.in_instr[32*i +: 32] = pool_instr[drv_idx[i]];
  endtask

  task automatic set_idx(input int a, input int b);
    drv_idx[0] = a;
    drv_idx[1] = b;
  endtask

  // Called just after a rising edge with inputs already driven. Checks the
  // outputs at the falling edge, then advances the model at the next edge.
  task automatic run_cycle();
    logic [39:0] cands[$];
    logic [39:0] e;
    int n, popped, cnt, id, occ_now;
    bit rdy, byp;
    @(negedge clk);
    occ_now = exp_q.size();
    cnt     = int'(bus.in_count);
    rdy     = (DEPTH - occ_now) >= FETCH_W;
    byp     = BYP && (occ_now == 0) && bus.in_valid && !bus.flush;
    cands   = {};
    if (byp) begin
      for (int i = 0; i < cnt; i++) cands.push_back({8'(drv_idx[i]), bus.in_pc + 32'(4 * i)});
    end else begin
      for (int i = 0; i < occ_now && i < DEC_W; i++) cands.push_back(exp_q[i]);
    end
    n = 0;
    for (int k = 0; k < DEC_W && k < cands.size(); k++) begin
      e  = cands[k];
      id = int'(e[39:32]);
      if (k > 0 && is_sys(id)) break;
      n++;
      if (is_cf(id) || is_sys(id)) break;
    end
    check("occupancy", 64'(bus.occupancy), 64'(occ_now));
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    check("out_valid", 64'(bus.out_valid), 64'((1 << n) - 1));
    for (int k = 0; k < n; k++) begin
      e  = cands[k];
      id = int'(e[39:32]);
      check("out_pc", 64'(bus.out_pc[32*k +: 32]), 64'(e[31:0]));
      check("out_opc", 64'(bus.out_info[k].opc), 64'(pool_opc[id]));
      check("out_cf", 64'(bus.out_info[k].cf_kind != CF_NONE), 64'(is_cf(id)));
    end
    @(posedge clk);
    popped = (bus.out_ready && !bus.flush) ? n : 0;
    if (bus.flush) begin
      exp_q.delete();
    end else if (byp) begin
      for (int i = popped; i < cnt; i++) exp_q.push_back({8'(drv_idx[i]), bus.in_pc + 32'(4 * i)});
    end else begin
      repeat (popped) void'(exp_q.pop_front());
      if (bus.in_valid && rdy)
        for (int i = 0; i < cnt; i++) exp_q.push_back({8'(drv_idx[i]), bus.in_pc + 32'(4 * i)});
    end
    #1;
  endtask

  task automatic idle(input bit ordy, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive(1'b0, 0, 32'h0, ordy, 1'b0);
      run_cycle();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    pool_instr = '{32'h00221821, 32'h00221823, 32'h10220004, 32'h08000010,
                   32'h03E00008, 32'h0000000C, 32'h8C220008, 32'hFC000000};
    pool_opc   = '{OPC_ALU, OPC_ALU, OPC_BRANCH, OPC_JUMP,
                   OPC_JUMP, OPC_SYSCALL, OPC_LOAD, OPC_INVALID};
    set_idx(0, 0);
    drive(1'b0, 0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_occupancy", 64'(bus.occupancy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Fill to 7, confirm back-pressure holds even while popping, then wrap.
    set_idx(0, 1); drive(1'b1, 2, 32'h2000, 1'b0, 1'b0); run_cycle();
    set_idx(1, 0); drive(1'b1, 2, 32'h2008, 1'b0, 1'b0); run_cycle();
    set_idx(6, 0); drive(1'b1, 2, 32'h2010, 1'b0, 1'b0); run_cycle();
    set_idx(0, 0); drive(1'b1, 1, 32'h2018, 1'b0, 1'b0); run_cycle();
    set_idx(1, 1); drive(1'b1, 2, 32'h2020, 1'b1, 1'b0); run_cycle();
    set_idx(6, 1); drive(1'b1, 2, 32'h2028, 1'b0, 1'b0); run_cycle();
    idle(1'b1, 6);

    // addu/subu pair at 0x1000, then branch-ended and syscall-ended groups.
    set_idx(0, 1); drive(1'b1, 2, 32'h1000, 1'b1, 1'b0); run_cycle();
    idle(1'b1, 2);
    set_idx(2, 0); drive(1'b1, 2, 32'h1100, 1'b0, 1'b0); run_cycle();
    idle(1'b1, 3);
    set_idx(0, 5); drive(1'b1, 2, 32'h1200, 1'b0, 1'b0); run_cycle();
    idle(1'b1, 3);
    set_idx(5, 0); drive(1'b1, 2, 32'hFFFFFFFC, 1'b0, 1'b0); run_cycle();
    idle(1'b1, 3);

    // Flush beats a simultaneous push and pop at occupancy 4.
    set_idx(0, 1); drive(1'b1, 2, 32'h3000, 1'b0, 1'b0); run_cycle();
    set_idx(1, 0); drive(1'b1, 2, 32'h3008, 1'b0, 1'b0); run_cycle();
    set_idx(0, 0); drive(1'b1, 2, 32'h3010, 1'b1, 1'b1); run_cycle();
    idle(1'b1, 2);

    // Asynchronous reset mid-cycle with 5 entries queued.
    set_idx(0, 1); drive(1'b1, 2, 32'h4000, 1'b0, 1'b0); run_cycle();
    set_idx(0, 1); drive(1'b1, 2, 32'h4008, 1'b0, 1'b0); run_cycle();
    set_idx(0, 1); drive(1'b1, 1, 32'h4010, 1'b0, 1'b0); run_cycle();
    drive(1'b0, 0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_occupancy", 64'(bus.occupancy), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomised traffic: alternate filling-biased and draining-biased phases.
    for (int c = 0; c < 800; c++) begin
      int rdy_pct;
      rdy_pct = ((c / 100) % 2 == 0) ? 30 : 85;
      for (int i = 0; i < FETCH_W; i++) drv_idx[i] = $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, FETCH_W),
            $urandom() & 32'hFFFF_FFFC, $urandom_range(1, 100) <= rdy_pct,
            $urandom_range(0, 39) == 0);
      run_cycle();
    end
    idle(1'b1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
